// File: rtl/freq_meter.sv
// Gated rising-edge counter for slow external signals; publishes one count per gate window.
// Optional period measurement between consecutive edges is built when FREQ_METER_PERIOD_EN is defined.
module freq_meter #(
  parameter int frequency = 27_000_000,
  parameter int gate_hz   = 1,
  parameter int COUNT_W   = 16,
  parameter int PERIOD_W  = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_count,
  output logic               valid,
  output logic               overflow,
  output logic               busy
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
`endif
);

  localparam int GATE_CYC = frequency / gate_hz;
  localparam int GW       = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [GW-1:0]      LAST = GW'(GATE_CYC - 1);
  localparam logic [COUNT_W-1:0] CMAX = {COUNT_W{1'b1}};

  if (COUNT_W < 1 || PERIOD_W < 1 || GATE_CYC < 2) begin : g_param_check
    $error("freq_meter: bad parameterisation");
  end

  // state | meaning
  // IDLE  | no window open, counters held at zero
  // GATE  | window open, counting detected rising edges
  typedef enum logic {IDLE = 1'b0, GATE = 1'b1} state_t;

  state_t             r_state;
  logic               r_s1, r_s2, r_s3;
  logic [GW-1:0]      r_gate_cnt;
  logic [COUNT_W-1:0] r_edge_cnt;
  logic               r_sat;
  logic [COUNT_W-1:0] r_freq_count;
  logic               r_valid;
  logic               r_overflow;
  logic               r_busy;

  logic               w_edge;
  logic               w_last;
  logic               w_edge_sat;
  logic               w_sat_any;
  logic [COUNT_W-1:0] w_edge_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge      = r_s2 & ~r_s3;
  assign w_last      = (r_gate_cnt == LAST);
  // An edge arriving while the count is already full is the one that gets lost.
  assign w_edge_sat  = w_edge && (r_edge_cnt == CMAX);
  assign w_sat_any   = r_sat | w_edge_sat;
  assign w_edge_next = w_edge_sat ? CMAX : r_edge_cnt + {{(COUNT_W-1){1'b0}}, w_edge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gate_cnt   <= '0;
      r_edge_cnt   <= '0;
      r_sat        <= 1'b0;
      r_freq_count <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (en) begin
            r_state <= GATE;
            r_busy  <= 1'b1;
          end
        end
        GATE: begin
          if (w_last) begin
            r_freq_count <= w_edge_next;
            r_overflow   <= w_sat_any;
            r_valid      <= 1'b1;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_sat        <= 1'b0;
            if (!en) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else if (!en) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
            r_edge_cnt <= w_edge_next;
            r_sat      <= w_sat_any;
          end
        end
      endcase
    end
  end

  assign freq_count = r_freq_count;
  assign valid      = r_valid;
  assign overflow   = r_overflow;
  assign busy       = r_busy;

`ifdef FREQ_METER_PERIOD_EN
  localparam logic [PERIOD_W-1:0] PMAX = {PERIOD_W{1'b1}};

  logic [PERIOD_W-1:0] r_per_cnt;
  logic                r_per_armed;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;

  // r_per_cnt restarts at 1 on each edge so its value at the next edge is the full interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_per_cnt      <= '0;
      r_per_armed    <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (!en) begin
        r_per_cnt   <= '0;
        r_per_armed <= 1'b0;
      end else if (w_edge) begin
        r_per_cnt   <= PERIOD_W'(1);
        r_per_armed <= 1'b1;
        if (r_per_armed) begin
          r_period       <= r_per_cnt;
          r_period_valid <= 1'b1;
        end
      end else if (r_per_cnt != PMAX) begin
        r_per_cnt <= r_per_cnt + PERIOD_W'(1);
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_period_valid;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter with a 1000-cycle gate and 8-bit count; window results checked through a queue.
`timescale 1ns/1ps
module tb_freq_meter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sig_in;
  logic [7:0] freq_count;
  logic       valid;
  logic       overflow;
  logic       busy;
`ifdef FREQ_METER_PERIOD_EN
  logic [24:0] period;
  logic        period_valid;
  int          pv_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int  cnt;
    bit  ovf;
    time t;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int half;
    int cnt;
    bit ovf;
  } vec_t;
  vec_t tbl[9];

  freq_meter #(
    .frequency(1000),
    .gate_hz  (1),
    .COUNT_W  (8),
    .PERIOD_W (25)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .freq_count(freq_count),
    .valid     (valid),
    .overflow  (overflow),
    .busy      (busy)
`ifdef FREQ_METER_PERIOD_EN
    ,
    .period      (period),
    .period_valid(period_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      if (q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("valid_time", longint'($time), longint'(e.t));
        check("freq_count", freq_count, e.cnt);
        check("overflow", overflow, e.ovf);
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  always @(negedge clk) begin
    if (period_valid) begin
      pv_count++;
      check("period", period, 50);
    end
  end
`endif

  task automatic start_gate();
    @(negedge clk);
    sig_in = 1'b0;
    en     = 1'b1;
  endtask

  // sig_in is forced low for the last four cycles so no edge straddles a window boundary.
  task automatic run_window(input int h, input int cnt, input bit ovf,
                            input int abort_at, input bit abort_rst, input bit close_low);
    for (int j = 1; j <= 1000; j++) begin
      @(negedge clk);
      if (j == 1 && abort_at == 0) q.push_back('{cnt, ovf, $time + 10000});
      if (abort_at != 0 && j == abort_at) begin
        sig_in = 1'b0;
        if (abort_rst) begin
          #2 rst = 1'b1;
          #1;
          check("rst_freq_count", freq_count, 0);
          check("rst_valid", valid, 0);
          check("rst_overflow", overflow, 0);
          check("rst_busy", busy, 0);
        end else begin
          en = 1'b0;
        end
        return;
      end
      sig_in = (h == 0 || j > 996) ? 1'b0 : 1'(((j - 1) / h) % 2);
      if (j == 500) check("busy_mid", busy, 1);
      if (close_low && j == 1000) en = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{10, 50, 1'b0};
    tbl[1] = '{1, 255, 1'b1};
    tbl[2] = '{10, 50, 1'b0};
    tbl[3] = '{5, 100, 1'b0};
    tbl[4] = '{2, 249, 1'b0};
    tbl[5] = '{0, 0, 1'b0};
    tbl[6] = '{4, 124, 1'b0};
    tbl[7] = '{3, 166, 1'b0};
    tbl[8] = '{10, 50, 1'b0};

    rst = 1'b0; en = 1'b0; sig_in = 1'b0;
`ifdef FREQ_METER_PERIOD_EN
    pv_count = 0;
`endif

    // reset with sig_in toggling, then idle with en low
    #2 rst = 1'b1;
    #1;
    check("init_freq_count", freq_count, 0);
    check("init_valid", valid, 0);
    check("init_overflow", overflow, 0);
    check("init_busy", busy, 0);
    for (int i = 0; i < 8; i++) #3 sig_in = ~sig_in;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      sig_in = 1'(i % 2);
    end
    check("idle_busy", busy, 0);
    check("idle_freq_count", freq_count, 0);
    sig_in = 1'b0;

    // back-to-back windows from the table; last one closes with en already low
    start_gate();
    for (int i = 0; i < 9; i++) run_window(tbl[i].half, tbl[i].cnt, tbl[i].ovf, 0, 1'b0, i == 8);
    @(negedge clk);
    check("close_low_busy", busy, 0);

    // abort at gate_cnt = 500 keeps the previous result
    start_gate();
    run_window(10, 50, 1'b0, 0, 1'b0, 1'b0);
    run_window(10, 0, 1'b0, 501, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_freq_count", freq_count, 50);
    for (int i = 0; i < 30; i++) @(negedge clk);
    check("abort_hold_count", freq_count, 50);
    start_gate();
    run_window(5, 100, 1'b0, 0, 1'b0, 1'b0);

    // async reset at gate_cnt = 700, then a full window after release
    run_window(10, 0, 1'b0, 701, 1'b1, 1'b0);
    @(negedge clk);
    check("rst_hold_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_window(10, 50, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check("end_busy", busy, 0);

`ifdef FREQ_METER_PERIOD_EN
    start_gate();
    pv_count = 0;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      sig_in = 1'(((j - 1) / 25) % 2);
    end
    sig_in = 1'b0;
    check("period_pulses", pv_count, 5);
    pv_count = 0;
    for (int j = 0; j < 200; j++) @(negedge clk);
    check("period_quiet", pv_count, 0);
    en = 1'b0;
    @(negedge clk);
`endif

    for (int i = 0; i < 5; i++) @(negedge clk);
    check("pending_valids", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
